// File: rtl/binary_to_bcd_signed.sv
// binary_to_bcd_signed: double-dabble binary-to-BCD converter with optional
// two's complement input, saturation on overflow, significant-digit count and
// a busy/done handshake. One shift per clock, so latency is INPUT_WIDTH+2
// clocks from the accepting edge to the edge that raises o_DV.
module binary_to_bcd_signed #(
  parameter int INPUT_WIDTH    = 10,
  parameter int DECIMAL_DIGITS = 3,
  parameter int SIGNED         = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  output logic                          o_Busy,
  output logic                          o_DV,
  output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic                          o_Sign,
  output logic                          o_Overflow,
  output logic [3:0]                    o_Num_Digits
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 stateQ, stateD;
  logic [INPUT_WIDTH-1:0] magQ, magD;
  logic [BCD_W-1:0]       bcdQ, bcdD;
  logic                   signQ, signD;
  logic                   ovfQ, ovfD;
  logic [CNT_W-1:0]       bitCntQ, bitCntD;

  logic                   dvQ, dvD;
  logic [BCD_W-1:0]       bcdOutQ, bcdOutD;
  logic                   signOutQ, signOutD;
  logic                   ovfOutQ, ovfOutD;
  logic [3:0]             numDigitsQ, numDigitsD;

  logic [BCD_W-1:0]       bcdCorr;
  logic [3:0]             sigDigits;
  logic                   valueZero;

  // Add-3 correction applied to every BCD digit in parallel before each shift.
  always_comb begin
    bcdCorr = bcdQ;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (bcdQ[4*i +: 4] > 4'd4) begin
        bcdCorr[4*i +: 4] = bcdQ[4*i +: 4] + 4'd3;
      end
    end
  end

  // Significant digits of the finished working value: highest nonzero digit + 1.
  always_comb begin
    sigDigits = 4'd1;
    valueZero = (bcdQ == '0) && !ovfQ;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (bcdQ[4*i +: 4] != 4'd0) begin
        sigDigits = 4'(i + 1);
      end
    end
  end

  // Next-state and datapath: capture, sign fix-up, shift loop, result publish.
  always_comb begin
    stateD     = stateQ;
    magD       = magQ;
    bcdD       = bcdQ;
    signD      = signQ;
    ovfD       = ovfQ;
    bitCntD    = bitCntQ;
    dvD        = 1'b0;
    bcdOutD    = bcdOutQ;
    signOutD   = signOutQ;
    ovfOutD    = ovfOutQ;
    numDigitsD = numDigitsQ;

    case (stateQ)
      IDLE: begin
        if (i_Start) begin
          magD   = i_Binary;
          stateD = PREP;
        end
      end

      PREP: begin
        // The most negative input negates to 2^(INPUT_WIDTH-1), which still
        // fits the unsigned magnitude register.
        if ((SIGNED != 0) && magQ[INPUT_WIDTH-1]) begin
          signD = 1'b1;
          magD  = ~magQ + INPUT_WIDTH'(1);
        end else begin
          signD = 1'b0;
        end
        bcdD    = '0;
        ovfD    = 1'b0;
        bitCntD = '0;
        stateD  = SHIFT;
      end

      SHIFT: begin
        // A one leaving the top digit means the value does not fit the digits.
        bcdD    = {bcdCorr[BCD_W-2:0], magQ[INPUT_WIDTH-1]};
        magD    = {magQ[INPUT_WIDTH-2:0], 1'b0};
        ovfD    = ovfQ | bcdCorr[BCD_W-1];
        bitCntD = bitCntQ + CNT_W'(1);
        if (bitCntQ == CNT_W'(INPUT_WIDTH - 1)) begin
          stateD = DONE;
        end
      end

      DONE: begin
        dvD      = 1'b1;
        bcdOutD  = ovfQ ? {DECIMAL_DIGITS{4'h9}} : bcdQ;
        signOutD = signQ & ~valueZero;
        ovfOutD  = ovfQ;
        numDigitsD = ovfQ ? 4'(DECIMAL_DIGITS) : sigDigits;
        stateD   = IDLE;
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      stateQ     <= IDLE;
      magQ       <= '0;
      bcdQ       <= '0;
      signQ      <= 1'b0;
      ovfQ       <= 1'b0;
      bitCntQ    <= '0;
      dvQ        <= 1'b0;
      bcdOutQ    <= '0;
      signOutQ   <= 1'b0;
      ovfOutQ    <= 1'b0;
      numDigitsQ <= 4'd1;
    end else begin
      stateQ     <= stateD;
      magQ       <= magD;
      bcdQ       <= bcdD;
      signQ      <= signD;
      ovfQ       <= ovfD;
      bitCntQ    <= bitCntD;
      dvQ        <= dvD;
      bcdOutQ    <= bcdOutD;
      signOutQ   <= signOutD;
      ovfOutQ    <= ovfOutD;
      numDigitsQ <= numDigitsD;
    end
  end

  assign o_Busy       = (stateQ != IDLE);
  assign o_DV         = dvQ;
  assign o_BCD        = bcdOutQ;
  assign o_Sign       = signOutQ;
  assign o_Overflow   = ovfOutQ;
  assign o_Num_Digits = numDigitsQ;

endmodule

// File: tb/tb_binary_to_bcd_signed.sv
// Directed and exhaustive checks of binary_to_bcd_signed on three
// configurations: W=10 unsigned, W=8 signed and W=8 unsigned (all 3 digits).
module tb_binary_to_bcd_signed;

   logic        clock;
   logic        reset;
   logic        start [3];
   logic [9:0]  bin10;
   logic [7:0]  bin8s;
   logic [7:0]  bin8u;
   logic        busy [3];
   logic        dv [3];
   logic [11:0] bcd [3];
   logic        sgn [3];
   logic        ovf [3];
   logic [3:0]  nDig [3];

   int nVectors = 0;
   int nMiss    = 0;
   int latency;
   int busyCnt;
   int dvCnt;

   binary_to_bcd_signed #(.INPUT_WIDTH(10), .DECIMAL_DIGITS(3), .SIGNED(0)) u0 (
      .i_Clock(clock), .i_Reset(reset), .i_Start(start[0]), .i_Binary(bin10),
      .o_Busy(busy[0]), .o_DV(dv[0]), .o_BCD(bcd[0]), .o_Sign(sgn[0]),
      .o_Overflow(ovf[0]), .o_Num_Digits(nDig[0]));

   binary_to_bcd_signed #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(1)) u1 (
      .i_Clock(clock), .i_Reset(reset), .i_Start(start[1]), .i_Binary(bin8s),
      .o_Busy(busy[1]), .o_DV(dv[1]), .o_BCD(bcd[1]), .o_Sign(sgn[1]),
      .o_Overflow(ovf[1]), .o_Num_Digits(nDig[1]));

   binary_to_bcd_signed #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(0)) u2 (
      .i_Clock(clock), .i_Reset(reset), .i_Start(start[2]), .i_Binary(bin8u),
      .o_Busy(busy[2]), .o_DV(dv[2]), .o_BCD(bcd[2]), .o_Sign(sgn[2]),
      .o_Overflow(ovf[2]), .o_Num_Digits(nDig[2]));

   // Free-running 100 MHz clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Decimal reference: digits by division, saturated to 999
   function automatic logic [11:0] refBcd(input int mag);
      if (mag > 999) return 12'h999;
      return {4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
   endfunction

   function automatic logic [3:0] refDigits(input int mag);
      if (mag >= 100) return 4'd3;
      if (mag >= 10)  return 4'd2;
      return 4'd1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nVectors++;
      assert (observed === expected) else begin
         nMiss++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present a value with i_Start for one edge, then scramble the input
   task automatic applyStimulus(input int dut, input int value);
      start[dut] = 1'b1;
      case (dut)
         0: bin10 = 10'(value);
         1: bin8s = 8'(value);
         default: bin8u = 8'(value);
      endcase
      @(posedge clock); #1;
      start[dut] = 1'b0;
      case (dut)
         0: bin10 = ~10'(value);
         1: bin8s = ~8'(value);
         default: bin8u = ~8'(value);
      endcase
   endtask

   // Count edges after the start edge until o_DV, bounded at 40
   task automatic waitDone(input int dut, output int lat, output int busyCycles);
      lat = -1;
      busyCycles = busy[dut] ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (dv[dut]) begin
            lat = k;
            break;
         end
         if (busy[dut]) busyCycles++;
      end
   endtask

   task automatic checkResult(input string tag, input int dut, input int expLat,
                              input logic [11:0] expBcd, input logic expSign,
                              input logic expOvf, input logic [3:0] expDig);
      checkOutput({tag, "_lat"}, latency, expLat);
      checkOutput({tag, "_bcd"}, bcd[dut], expBcd);
      checkOutput({tag, "_sign"}, sgn[dut], expSign);
      checkOutput({tag, "_ovf"}, ovf[dut], expOvf);
      checkOutput({tag, "_ndig"}, nDig[dut], expDig);
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      bin10 = '0;
      bin8s = '0;
      bin8u = '0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_busy", busy[0], 1'b0);
      checkOutput("rst_dv", dv[0], 1'b0);
      checkOutput("rst_bcd", bcd[0], 12'h000);
      checkOutput("rst_ndig", nDig[0], 4'd1);
      reset = 1'b0;
      @(posedge clock); #1;

      // 255 on W=10: 12-cycle latency, busy for 12 cycles
      applyStimulus(0, 255);
      waitDone(0, latency, busyCnt);
      checkResult("u255", 0, 12, 12'h255, 1'b0, 1'b0, 4'd3);
      checkOutput("u255_busy", busyCnt, 12);
      checkOutput("u255_busy_low", busy[0], 1'b0);
      @(posedge clock); #1;
      checkOutput("u255_dv_pulse", dv[0], 1'b0);
      checkOutput("u255_hold", bcd[0], 12'h255);

      // Overflow saturates, then the largest fitting value
      applyStimulus(0, 1023);
      waitDone(0, latency, busyCnt);
      checkResult("u1023", 0, 12, 12'h999, 1'b0, 1'b1, 4'd3);
      @(posedge clock); #1;
      applyStimulus(0, 999);
      waitDone(0, latency, busyCnt);
      checkResult("u999", 0, 12, 12'h999, 1'b0, 1'b0, 4'd3);
      @(posedge clock); #1;

      // Signed corners on W=8
      applyStimulus(1, 8'h80);
      waitDone(1, latency, busyCnt);
      checkResult("sm128", 1, 10, 12'h128, 1'b1, 1'b0, 4'd3);
      @(posedge clock); #1;
      applyStimulus(1, 8'hF9);
      waitDone(1, latency, busyCnt);
      checkResult("sm7", 1, 10, 12'h007, 1'b1, 1'b0, 4'd1);
      @(posedge clock); #1;
      applyStimulus(1, 0);
      waitDone(1, latency, busyCnt);
      checkResult("s0", 1, 10, 12'h000, 1'b0, 1'b0, 4'd1);
      @(posedge clock); #1;

      // Start while busy is ignored; start in the o_DV cycle is accepted
      applyStimulus(0, 42);
      repeat (3) @(posedge clock);
      #1;
      start[0] = 1'b1;
      bin10 = 10'd99;
      @(posedge clock); #1;
      start[0] = 1'b0;
      waitDone(0, latency, busyCnt);
      latency = latency + 4;
      checkResult("u42", 0, 12, 12'h042, 1'b0, 1'b0, 4'd2);
      applyStimulus(0, 99);
      checkOutput("b2b_dv_low", dv[0], 1'b0);
      checkOutput("b2b_busy", busy[0], 1'b1);
      waitDone(0, latency, busyCnt);
      checkResult("u99", 0, 12, 12'h099, 1'b0, 1'b0, 4'd2);
      @(posedge clock); #1;

      // Reset five cycles into a conversion aborts it without o_DV
      applyStimulus(0, 500);
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", busy[0], 1'b0);
      checkOutput("abort_dv", dv[0], 1'b0);
      checkOutput("abort_bcd", bcd[0], 12'h000);
      checkOutput("abort_ndig", nDig[0], 4'd1);
      @(posedge clock); #1;
      reset = 1'b0;
      dvCnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (dv[0]) dvCnt++;
      end
      checkOutput("abort_no_dv", dvCnt, 0);
      applyStimulus(0, 7);
      waitDone(0, latency, busyCnt);
      checkResult("u7", 0, 12, 12'h007, 1'b0, 1'b0, 4'd1);
      @(posedge clock); #1;

      // Every W=8 input, unsigned then signed, against the decimal reference
      for (int v = 0; v < 256; v++) begin
         applyStimulus(2, v);
         waitDone(2, latency, busyCnt);
         checkResult("exu", 2, 10, refBcd(v), 1'b0, 1'b0, refDigits(v));
      end
      for (int v = 0; v < 256; v++) begin
         int mag;
         mag = (v >= 128) ? 256 - v : v;
         applyStimulus(1, v);
         waitDone(1, latency, busyCnt);
         checkResult("exs", 1, 10, refBcd(mag), (v >= 128), 1'b0, refDigits(mag));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
